// File: rtl/fifo_levels.sv
// fifo_levels: single-clock valid/ack FIFO with arbitrary depth, live fill
// count, programmable almost-full/almost-empty flags, synchronous flush and
// a peak-occupancy watermark.
module fifo_levels #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 64,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           in,
    input  logic                       in_valid,
    output logic                       in_ack,
    output logic [WIDTH-1:0]           out,
    output logic                       out_valid,
    input  logic                       out_ack,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] peak
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic             full;
    logic             empty;
    logic             wr;
    logic             rd;
    logic [CW-1:0]    next_count;
    logic [CW-1:0]    next_peak;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign in_ack       = reset_n && !full && !flush;
    assign out_valid    = !empty && !flush;
    assign out          = out_valid ? mem[head] : '0;
    assign wr           = in_valid && in_ack;
    assign rd           = out_valid && out_ack;
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    // Occupancy after this edge, and the watermark that follows from it.
    always_comb begin
        next_count = count;
        if (flush) begin
            next_count = '0;
        end else if (wr && !rd) begin
            next_count = count + CW'(1);
        end else if (rd && !wr) begin
            next_count = count - CW'(1);
        end
        next_peak = (next_count > peak) ? next_count : peak;
        if (flush) begin
            next_peak = '0;
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clock) begin
        if (wr) begin
            mem[tail] <= in;
        end
    end

    // Control state: pointers, count and watermark.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            peak  <= '0;
        end else begin
            count <= next_count;
            peak  <= next_peak;
            if (flush) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (wr) begin
                    tail <= next_ptr(tail);
                end
                if (rd) begin
                    head <= next_ptr(head);
                end
            end
        end
    end

`ifdef FORMAL
    logic [PW:0]      f_diff;
    logic             f_armed;
    logic [WIDTH-1:0] f_data;
    logic [CW-1:0]    f_ahead;
    logic             f_past_hold;
    logic [WIDTH-1:0] f_past_out;

    assign f_diff = (tail >= head) ? {1'b0, tail} - {1'b0, head}
                                   : {1'b0, tail} + (PW+1)'(DEPTH) - {1'b0, head};

    // Track the first word written after reset/flush and prove it leaves in order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            f_armed     <= 1'b0;
            f_data      <= '0;
            f_ahead     <= '0;
            f_past_hold <= 1'b0;
            f_past_out  <= '0;
        end else begin
            f_past_hold <= out_valid && !out_ack;
            f_past_out  <= out;
            if (flush) begin
                f_armed <= 1'b0;
            end else if (!f_armed && wr) begin
                f_armed <= 1'b1;
                f_data  <= in;
                f_ahead <= count - (rd ? CW'(1) : CW'(0));
            end else if (f_armed && rd) begin
                if (f_ahead == '0) begin
                    f_armed <= 1'b0;
                end else begin
                    f_ahead <= f_ahead - CW'(1);
                end
            end
        end
    end

    always_comb begin
        if (reset_n) begin
            assert (count <= CW'(DEPTH));
            assert (peak >= count);
            if (count == CW'(DEPTH)) begin
                assert (tail == head);
            end else begin
                assert (f_diff == (PW+1)'(count));
            end
            if (f_armed && f_ahead == '0 && out_valid) begin
                assert (out == f_data);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n && f_past_hold && !flush) begin
            assert (out_valid && out == f_past_out);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_levels.sv
// Directed testbench for fifo_levels with DEPTH=5, WIDTH=8, AF_LEVEL=3, AE_LEVEL=2.
module tb_fifo_levels;

    logic       clock;
    logic       reset_n;
    logic [7:0] in;
    logic       in_valid;
    logic       in_ack;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ack;
    logic       flush;
    logic [2:0] count;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] peak;

    int checks = 0;
    int errors = 0;

    fifo_levels #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(2)) dut (
        .clock(clock), .reset_n(reset_n), .in(in), .in_valid(in_valid),
        .in_ack(in_ack), .out(out), .out_valid(out_valid), .out_ack(out_ack),
        .flush(flush), .count(count), .almost_full(almost_full),
        .almost_empty(almost_empty), .peak(peak)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in = '0; in_valid = 0; out_ack = 0; flush = 0;
        #12;
        checks++; if (in_ack !== 1'b0) begin errors++; $display("FAIL reset_in_ack got %b exp 0", in_ack); end
        checks++; if (out_valid !== 1'b0 || out !== 8'h00) begin errors++; $display("FAIL reset_out got %b/%h exp 0/00", out_valid, out); end
        checks++; if (count !== 3'd0 || peak !== 3'd0) begin errors++; $display("FAIL reset_count got %0d/%0d exp 0/0", count, peak); end
        checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin errors++; $display("FAIL reset_flags got ae=%b af=%b exp 1/0", almost_empty, almost_full); end
        reset_n = 1'b1;
        #1;
        checks++; if (in_ack !== 1'b1) begin errors++; $display("FAIL release_in_ack got %b exp 1", in_ack); end
        tick();
    endtask

    task automatic test_write();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            in = vals[i]; in_valid = 1;
            tick();
            checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL write_count%0d got %0d exp %0d", i, count, i + 1); end
            checks++; if (out_valid !== 1'b1 || out !== 8'h11) begin errors++; $display("FAIL write_head%0d got %b/%h exp 1/11", i, out_valid, out); end
        end
        in_valid = 0;
        #1;
        checks++; if (almost_empty !== 1'b0) begin errors++; $display("FAIL write_ae got %b exp 0", almost_empty); end
        checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL write_af got %b exp 1", almost_full); end
        checks++; if (peak !== 3'd3) begin errors++; $display("FAIL write_peak got %0d exp 3", peak); end
    endtask

    task automatic test_fill();
        in = 8'h44; in_valid = 1; tick();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count4 got %0d exp 4", count); end
        in = 8'h55; tick();
        checks++; if (count !== 3'd5 || in_ack !== 1'b0) begin errors++; $display("FAIL fill_full got cnt=%0d ack=%b exp 5/0", count, in_ack); end
        in = 8'h66; tick();
        checks++; if (count !== 3'd5 || out !== 8'h11) begin errors++; $display("FAIL fill_reject got cnt=%0d out=%h exp 5/11", count, out); end
        checks++; if (almost_full !== 1'b1 || peak !== 3'd5) begin errors++; $display("FAIL fill_af_peak got af=%b peak=%0d exp 1/5", almost_full, peak); end
        in_valid = 0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] din  [7];
        logic [7:0] dexp [7];
        logic [7:0] drain [4];
        din[0] = 8'h66; din[1] = 8'h66; din[2] = 8'h77; din[3] = 8'h88;
        din[4] = 8'h99; din[5] = 8'hAA; din[6] = 8'hBB;
        dexp[0] = 8'h22; dexp[1] = 8'h33; dexp[2] = 8'h44; dexp[3] = 8'h55;
        dexp[4] = 8'h66; dexp[5] = 8'h77; dexp[6] = 8'h88;
        drain[0] = 8'h99; drain[1] = 8'hAA; drain[2] = 8'hBB; drain[3] = 8'h00;
        out_ack = 1; in_valid = 1;
        for (int i = 0; i < 7; i++) begin
            in = din[i];
            tick();
            checks++; if (count !== 3'd4) begin errors++; $display("FAIL b2b_count%0d got %0d exp 4", i, count); end
            checks++; if (out !== dexp[i]) begin errors++; $display("FAIL b2b_out%0d got %h exp %h", i, out, dexp[i]); end
        end
        in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (out !== drain[i] || count !== 3'(3 - i)) begin errors++; $display("FAIL drain%0d got out=%h cnt=%0d exp %h/%0d", i, out, count, drain[i], 3 - i); end
        end
        checks++; if (out_valid !== 1'b0 || peak !== 3'd5) begin errors++; $display("FAIL drain_end got v=%b peak=%0d exp 0/5", out_valid, peak); end
        out_ack = 0;
    endtask

    task automatic test_empty_same_cycle();
        in = 8'hA5; in_valid = 1; out_ack = 1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nofall_valid got %b exp 0", out_valid); end
        tick();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1 || out !== 8'hA5 || count !== 3'd1) begin errors++; $display("FAIL nofall_next got %b/%h/%0d exp 1/a5/1", out_valid, out, count); end
        tick();
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL nofall_read got cnt=%0d v=%b exp 0/0", count, out_valid); end
        out_ack = 0;
    endtask

    task automatic test_flush();
        in_valid = 1;
        for (int i = 1; i <= 4; i++) begin
            in = 8'(i); tick();
        end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL flush_pre got %0d exp 4", count); end
        in = 8'hEE; flush = 1;
        #1;
        checks++; if (in_ack !== 1'b0 || out_valid !== 1'b0 || out !== 8'h00) begin errors++; $display("FAIL flush_during got ack=%b v=%b out=%h exp 0/0/00", in_ack, out_valid, out); end
        tick();
        flush = 0; in_valid = 0;
        #1;
        checks++; if (count !== 3'd0 || peak !== 3'd0) begin errors++; $display("FAIL flush_after got cnt=%0d peak=%0d exp 0/0", count, peak); end
        checks++; if (out !== 8'h00 || in_ack !== 1'b1) begin errors++; $display("FAIL flush_after_io got out=%h ack=%b exp 00/1", out, in_ack); end
        in = 8'h3C; in_valid = 1; tick();
        in_valid = 0; out_ack = 1;
        checks++; if (out !== 8'h3C || peak !== 3'd1) begin errors++; $display("FAIL flush_reuse got out=%h peak=%0d exp 3c/1", out, peak); end
        tick();
        out_ack = 0; flush = 1; tick();
        flush = 0;
        checks++; if (peak !== 3'd0 || count !== 3'd0) begin errors++; $display("FAIL flush_empty got peak=%0d cnt=%0d exp 0/0", peak, count); end
    endtask

    task automatic test_async_reset();
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in = 8'hC0 + 8'(i); tick();
        end
        in_valid = 0;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL areset_pre got %0d exp 3", count); end
        #2;
        reset_n = 0;
        #1;
        checks++; if (count !== 3'd0 || peak !== 3'd0 || out_valid !== 1'b0 || out !== 8'h00) begin errors++; $display("FAIL areset_now got cnt=%0d peak=%0d v=%b out=%h exp 0/0/0/00", count, peak, out_valid, out); end
        checks++; if (in_ack !== 1'b0 || almost_empty !== 1'b1) begin errors++; $display("FAIL areset_flags got ack=%b ae=%b exp 0/1", in_ack, almost_empty); end
        tick();
        #2;
        reset_n = 1;
        #1;
        checks++; if (in_ack !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL areset_release got ack=%b cnt=%0d exp 1/0", in_ack, count); end
        in = 8'h5A; in_valid = 1; tick();
        in_valid = 0;
        checks++; if (out !== 8'h5A || count !== 3'd1) begin errors++; $display("FAIL areset_reuse got out=%h cnt=%0d exp 5a/1", out, count); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_fill();
        test_back_to_back();
        test_empty_same_cycle();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
